lfsr_rand_sched: RTL and testbench



---
 rtl/lfsr_pkg.sv | 10 +
 rtl/lfsr_rand_sched_if.sv | 14 +
 rtl/lfsr_core.sv | 20 ++
 rtl/lfsr_rand_sched.sv | 73 +++++++
 tb/tb_lfsr_rand_sched.sv | 139 +++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR constants, FSM states and the Galois step function
package lfsr_pkg;
  localparam int LFSR_WIDTH = 32;
  localparam logic [LFSR_WIDTH-1:0] DEF_TAPS = 32'h80200003;
  localparam logic [LFSR_WIDTH-1:0] DEF_SEED = 32'hACE10001;
  typedef enum logic {WARMUP, READY} fsm_e;
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s, input logic [LFSR_WIDTH-1:0] taps);
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction
endpackage

// File: rtl/lfsr_rand_sched_if.sv
// lfsr_rand_sched_if: seed, request/grant and random-word bus of the scheduler
interface lfsr_rand_sched_if #(parameter int NREQ = 4, parameter int WIDTH = 32);
  logic seed_valid;
  logic [WIDTH-1:0] seed_data;
  logic seed_ready;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic rnd_valid;
  logic [WIDTH-1:0] rnd_data;
  logic busy;
  logic lockup;
  modport master(output seed_valid, seed_data, req, input seed_ready, gnt, rnd_valid, rnd_data, busy, lockup);
  modport slave(input seed_valid, seed_data, req, output seed_ready, gnt, rnd_valid, rnd_data, busy, lockup);
endinterface

// File: rtl/lfsr_core.sv
// lfsr_core: Galois LFSR register; load overrides step
module lfsr_core import lfsr_pkg::*; #(
  parameter int WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS = DEF_TAPS,
  parameter logic [WIDTH-1:0] SEED = DEF_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [WIDTH-1:0] load_val,
  input  logic step,
  output logic [WIDTH-1:0] state
);
  logic [WIDTH-1:0] state_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= SEED;
    else if (load) state_q <= load_val;
    else if (step) state_q <= lfsr_next(state_q, TAPS);
  assign state = state_q;
endmodule

// File: rtl/lfsr_rand_sched.sv
// lfsr_rand_sched: round-robin distribution of Galois LFSR words with seeding and warm-up
module lfsr_rand_sched import lfsr_pkg::*; #(
  parameter int NREQ = 4,
  parameter int WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS = DEF_TAPS,
  parameter logic [WIDTH-1:0] SEED = DEF_SEED,
  parameter int WARM = 16
) (
  input logic clk,
  input logic rst,
  lfsr_rand_sched_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  fsm_e fsm_q;
  logic [7:0] cnt_q;
  logic [PW-1:0] ptr_q, win_d, idx;
  logic [NREQ-1:0] gnt_q;
  logic rnd_valid_q, lockup_q, hit, zero, take_seed, grant, load, step;
  logic [WIDTH-1:0] rnd_data_q, state, load_val;
  lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_core (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .step(step), .state(state)
  );
  // descending scan so the nearest set bit after ptr_q is written last
  always_comb begin
    win_d = ptr_q;
    hit = 1'b0;
    idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = PW'((int'(ptr_q) + i) % NREQ);
      if (bus.req[idx]) begin
        win_d = idx;
        hit = 1'b1;
      end
    end
  end
  assign zero = state == '0;
  assign take_seed = fsm_q == READY && !zero && bus.seed_valid;
  assign grant = fsm_q == READY && !zero && !bus.seed_valid && hit;
  assign load = zero || take_seed;
  assign load_val = (zero || bus.seed_data == '0) ? SEED : bus.seed_data;
  assign step = fsm_q == WARMUP || grant;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fsm_q <= WARMUP;
      cnt_q <= '0;
      ptr_q <= PW'(NREQ - 1);
      gnt_q <= '0;
      rnd_valid_q <= 1'b0;
      rnd_data_q <= '0;
      lockup_q <= 1'b0;
    end else begin
      gnt_q <= grant ? (NREQ'(1) << win_d) : '0;
      rnd_valid_q <= grant;
      if (grant) begin
        rnd_data_q <= state;
        ptr_q <= win_d;
      end
      if (zero) lockup_q <= 1'b1;
      if (fsm_q == WARMUP) begin
        cnt_q <= cnt_q == 8'(WARM - 1) ? '0 : cnt_q + 8'd1;
        if (cnt_q == 8'(WARM - 1)) fsm_q <= READY;
      end else if (take_seed) begin
        cnt_q <= '0;
        fsm_q <= WARMUP;
      end
    end
  assign bus.gnt = gnt_q;
  assign bus.rnd_valid = rnd_valid_q;
  assign bus.rnd_data = rnd_data_q;
  assign bus.busy = fsm_q == WARMUP;
  assign bus.seed_ready = fsm_q == READY;
  assign bus.lockup = lockup_q;
endmodule

// File: tb/tb_lfsr_rand_sched.sv
// tb_lfsr_rand_sched: vector tables plus scoreboard for the LFSR request scheduler
module tb_lfsr_rand_sched;
  typedef struct {
    logic [3:0] req;
    logic sv;
    logic [31:0] sd;
    logic zap;
    logic [3:0] gnt;
    logic [31:0] data;
    logic busy;
    logic lock;
  } vec_t;
  localparam logic [31:0] S1 = 32'h80200003, S2 = 32'hC0300002, S3 = 32'h60180001, S4 = 32'hB02C0003;
  localparam logic [31:0] S5 = 32'hD8360002, S6 = 32'h6C1B0001, S7 = 32'hB62D8003, S8 = 32'hDB36C002;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t tv[$];
  vec_t sb[$];
  always #5 clk = ~clk;
  lfsr_rand_sched_if #(.NREQ(4), .WIDTH(32)) bus();
  lfsr_rand_sched #(.NREQ(4), .WIDTH(32), .TAPS(32'h80200003), .SEED(32'h1), .WARM(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  function automatic vec_t mk(logic [3:0] req, logic sv, logic [31:0] sd, logic zap,
                              logic [3:0] gnt, logic [31:0] data, logic busy, logic lock);
    vec_t v;
    v.req = req; v.sv = sv; v.sd = sd; v.zap = zap;
    v.gnt = gnt; v.data = data; v.busy = busy; v.lock = lock;
    return v;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    bus.req = v.req;
    bus.seed_valid = v.sv;
    bus.seed_data = v.sd;
    sb.push_back(v);
    if (v.zap) begin
      force dut.u_core.state_q = 32'h0;
      #1;
      release dut.u_core.state_q;
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("gnt", 32'(bus.gnt), 32'(e.gnt));
    chk("rnd_valid", 32'(bus.rnd_valid), 32'(|e.gnt));
    chk("rnd_data", bus.rnd_data, e.data);
    chk("busy", 32'(bus.busy), 32'(e.busy));
    chk("seed_ready", 32'(bus.seed_ready), 32'(!e.busy));
    chk("lockup", 32'(bus.lockup), 32'(e.lock));
  endtask
  task automatic run();
    for (int i = 0; i < tv.size(); i++) apply(tv[i]);
    tv.delete();
  endtask
  task automatic check_reset();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_rnd_valid", 32'(bus.rnd_valid), 32'h0);
    chk("rst_rnd_data", bus.rnd_data, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h1);
    chk("rst_seed_ready", 32'(bus.seed_ready), 32'h0);
    chk("rst_lockup", 32'(bus.lockup), 32'h0);
  endtask
  task automatic release_rst(input logic [3:0] req);
    @(negedge clk);
    bus.req = req;
    rst = 1'b0;
    #1;
    chk("warm_busy", 32'(bus.busy), 32'h1);
    @(posedge clk);
    #1;
    chk("warm_gnt", 32'(bus.gnt), 32'h0);
    chk("ready_busy", 32'(bus.busy), 32'h0);
    chk("ready_seed_ready", 32'(bus.seed_ready), 32'h1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.req = '0;
    bus.seed_valid = 1'b0;
    bus.seed_data = '0;
    #1;
    check_reset();
    release_rst(4'b0000);
    tv.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 32'h0, 0, 0));
    tv.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 32'h0, 0, 0));
    tv.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, S1, 0, 0));
    tv.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, S2, 0, 0));
    tv.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, S3, 0, 0));
    tv.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, S3, 0, 0));
    run();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset();
    release_rst(4'b1111);
    tv.push_back(mk(4'b1111, 0, 0, 0, 4'b0001, S1, 0, 0));
    tv.push_back(mk(4'b1111, 0, 0, 0, 4'b0010, S2, 0, 0));
    tv.push_back(mk(4'b1111, 0, 0, 0, 4'b0100, S3, 0, 0));
    tv.push_back(mk(4'b1111, 0, 0, 0, 4'b1000, S4, 0, 0));
    tv.push_back(mk(4'b0101, 0, 0, 0, 4'b0001, S5, 0, 0));
    tv.push_back(mk(4'b0101, 0, 0, 0, 4'b0100, S6, 0, 0));
    tv.push_back(mk(4'b0101, 0, 0, 0, 4'b0001, S7, 0, 0));
    tv.push_back(mk(4'b0101, 0, 0, 0, 4'b0100, S8, 0, 0));
    // zero seed with a competing request: reseed wins, warm-up reruns
    tv.push_back(mk(4'b0010, 1, 32'h0, 0, 4'b0000, S8, 1, 0));
    tv.push_back(mk(4'b0010, 0, 32'h0, 0, 4'b0000, S8, 0, 0));
    tv.push_back(mk(4'b0010, 0, 32'h0, 0, 4'b0010, S1, 0, 0));
    tv.push_back(mk(4'b0100, 0, 32'h0, 0, 4'b0100, S2, 0, 0));
    run();
    rst = 1'b1;
    #1;
    chk("midrst_gnt", 32'(bus.gnt), 32'h0);
    chk("midrst_rnd_data", bus.rnd_data, 32'h0);
    check_reset();
    release_rst(4'b0100);
    tv.push_back(mk(4'b0100, 0, 0, 0, 4'b0100, S1, 0, 0));
    tv.push_back(mk(4'b0001, 0, 0, 1, 4'b0000, S1, 0, 1));
    tv.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 32'h1, 0, 1));
    tv.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, S1, 0, 1));
    run();
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
